// File: rtl/pattern_slot_arbiter.sv
// Round-robin arbiter that grants one requester at a time the shared
// pattern-evaluation datapath, with a completion timeout and a sticky error flag.
module pattern_slot_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned TMO   = 15
) (
  input  logic                       blif_clk_net,
  input  logic                       blif_reset_net,
  input  logic [N_REQ-1:0]           req_i,
  output logic [$clog2(N_REQ)-1:0]   sel_o,
  output logic                       start_o,
  input  logic                       dp_done_i,
  output logic [N_REQ-1:0]           ack_o,
  output logic                       busy_o,
  output logic                       err_o
);

  localparam int unsigned SEL_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ACK    = 2'd3
  } state_e;

  // Reset asserts immediately but releases two clock edges after the input drops.
  logic [1:0] rst_sync_q;
  logic       rst_int;

  always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
    if (blif_reset_net) begin
      rst_sync_q <= 2'b11;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
  end

  assign rst_int = rst_sync_q[1];

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [SEL_W-1:0]     last_q, last_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 start_q, start_d;
  logic [N_REQ-1:0]     ack_q, ack_d;
  logic                 busy_q, busy_d;

  logic [SEL_W-1:0]     pick_c;
  logic [SEL_W-1:0]     cand_c;
  logic                 found_c;

  // First set request searching upward from the requester after last, wrapping.
  always_comb begin
    pick_c  = last_q;
    cand_c  = '0;
    found_c = 1'b0;
    for (int i = 1; i <= int'(N_REQ); i++) begin
      cand_c = SEL_W'((int'(last_q) + i) % int'(N_REQ));
      if (!found_c && req_i[cand_c]) begin
        pick_c  = cand_c;
        found_c = 1'b1;
      end
    end
  end

  always_ff @(posedge blif_clk_net or posedge rst_int) begin
    if (rst_int) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      last_q  <= SEL_W'(N_REQ - 1);
      cnt_q   <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      start_q <= start_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  // Outputs are computed for the upcoming state so they register in step with it.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    start_d = 1'b0;
    ack_d   = '0;
    busy_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (found_c) begin
          sel_d   = pick_c;
          start_d = 1'b1;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (dp_done_i) begin
          ack_d[sel_q] = 1'b1;
          state_d      = ST_ACK;
        end else if (cnt_q >= CNT_W'(TMO - 1)) begin
          // Counter saturates at TMO; the transaction is dropped without an ack.
          cnt_d   = CNT_W'(TMO);
          err_d   = 1'b1;
          last_d  = sel_q;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ACK: begin
        last_d  = sel_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign sel_o   = sel_q;
  assign start_o = start_q;
  assign ack_o   = ack_q;
  assign busy_o  = busy_q;
  assign err_o   = err_q;

endmodule

// File: doc/pattern_slot_arbiter.md
PATTERN_SLOT_ARBITER -- requirements
Module: pattern_slot_arbiter

Interface
REQ-001 Parameter: N_REQ, default 4, number of requesters sharing the pattern-evaluation datapath (2..8).
REQ-002 Parameter: TMO, default 15, maximum WAIT cycles before the transaction is abandoned (1..255).
REQ-003 Ports, in order:
- blif_clk_net  input  1  single clock; all state is on its rising edge.
- blif_reset_net  input  1  asynchronous, active-high reset.
- req_i  input  N_REQ  level requests; each bit is held until its ack.
- sel_o  output  clog2(N_REQ)  index of the served requester; drives the datapath input mux.
- start_o  output  1  one-cycle launch pulse to the datapath.
- dp_done_i  input  1  datapath completion pulse.
- ack_o  output  N_REQ  one-hot, one-cycle completion ack.
- busy_o  output  1  high in any state except IDLE.
- err_o  output  1  sticky timeout flag.

Function
REQ-004 The FSM SHALL have states IDLE, LAUNCH, WAIT and ACK, encoded in registers.
REQ-005 IDLE SHALL do the following:
- If req_i is nonzero, register sel_o as the first set bit searching round-robin from last+1 (wrapping N_REQ-1 to 0), then go to LAUNCH.
- Otherwise stay in IDLE.
REQ-006 LAUNCH SHALL assert start_o for exactly one cycle, clear the wait counter, then go to WAIT.
REQ-007 WAIT SHALL go to ACK on the cycle dp_done_i=1.
REQ-008 In WAIT with dp_done_i=0, the counter SHALL increment each cycle.
REQ-009 When the counter reaches TMO with dp_done_i=0, the FSM SHALL set err_o, go to IDLE without any ack, and update last to sel_o.
REQ-010 ACK SHALL assert ack_o[sel_o] for exactly one cycle, set last=sel_o, then go to IDLE.
REQ-011 Latency SHALL be as follows:
- req_i seen in IDLE at cycle t gives start_o at t+1.
- dp_done_i at cycle u gives ack_o at u+1.
- The next grant is no earlier than u+2.
REQ-012 sel_o SHALL stay stable from the LAUNCH cycle through the ACK cycle.
REQ-013 dp_done_i SHALL be ignored in IDLE, LAUNCH and ACK.
REQ-014 dp_done_i coincident with counter==TMO SHALL count as completion: ACK, no error.
REQ-015 If the served req_i bit drops mid-transaction, the transaction SHALL still complete and ack_o SHALL still pulse.
REQ-016 New or changed req_i bits during LAUNCH, WAIT or ACK SHALL NOT alter sel_o; they are arbitrated at the next IDLE.
REQ-017 Requests SHALL be checked for starvation freedom: with all bits held, each requester is served once per N_REQ grants.
REQ-018 ack_o SHALL be zero outside ACK.
REQ-019 start_o SHALL be zero outside LAUNCH.
REQ-020 At most one ack_o bit SHALL be set in any cycle.
REQ-021 err_o SHALL clear only on reset.
REQ-022 The counter SHALL saturate and never wrap.

Reset
REQ-023 Asserting blif_reset_net SHALL immediately, without a clock edge, force the following:
- state IDLE, last=N_REQ-1, sel_o=0;
- start_o=0, ack_o=0, busy_o=0;
- counter=0, err_o=0.
REQ-024 Reset mid-transaction SHALL abandon the transaction and emit no ack.
REQ-025 After reset releases, arbitration SHALL start at requester 0.
REQ-026 Deassertion of blif_reset_net SHALL be synchronized to blif_clk_net with a 2-flop synchronizer.

Verification
REQ-027 The bench SHALL cover these directed scenarios (defaults N_REQ=4, TMO=15):
- Single request: req_i=0010 at t0, dp_done_i at t0+4 -> start_o at t0+1, sel_o=1, ack_o=0010 at t0+5, busy_o low at t0+6.
- Round-robin: req_i=1111 held, dp_done_i 2 cycles after each start -> grant order 0,1,2,3,0; each ack_o one-hot.
- Timeout: req_i=0100, dp_done_i never asserted -> err_o=1 after 15 WAIT cycles, no ack_o, return to IDLE; next req_i=0100 is served normally with err_o still 1.
- Boundary: dp_done_i on the TMO-th WAIT cycle -> ack_o pulses and err_o stays 0.
- Stray and dropped signals: dp_done_i pulsed in IDLE -> no state change; req dropped during WAIT -> ack_o still issued.
- Reset mid-WAIT: blif_reset_net high for 1 cycle -> outputs zero asynchronously, no ack; then req_i=1000 -> sel_o=3, with the next tie resolving to requester 0 first.
